// File: rtl/lct_mpc_tx.sv
// rtl/lct_mpc_tx.sv - LCT pair to MPC transmitter with accept window and status counters
// Optional quality sort of the two LCTs into lanes A/B is enabled by defining LCT_SORT_EN.
module lct_mpc_tx #(
   parameter int ACC_WIN  = 8,
   parameter int CNT_BITS = 16
) (
   input  logic                clock,
   input  logic                global_reset,
   input  logic                lct_vld,
   input  logic                lct0_vld,
   input  logic                lct1_vld,
   input  logic [3:0]          lct0_q,
   input  logic [3:0]          lct1_q,
   input  logic [3:0]          lct0_pat,
   input  logic [3:0]          lct1_pat,
   input  logic [7:0]          lct0_key,
   input  logic [7:0]          lct1_key,
   input  logic                lct0_bend,
   input  logic                lct1_bend,
   input  logic [6:0]          lct0_wg,
   input  logic [6:0]          lct1_wg,
   input  logic [1:0]          bxn,
   input  logic [3:0]          csc_id,
   input  logic                sync_err,
   output logic [15:0]         mpc_frame_a,
   output logic [15:0]         mpc_frame_b,
   output logic                mpc_tx_vld,
   input  logic                mpc_accept_vld,
   input  logic [1:0]          mpc_accept,
   output logic [1:0]          lct_accepted,
   output logic                accept_done,
   output logic                mpc_timeout,
   output logic [CNT_BITS-1:0] cnt_sent,
   output logic [CNT_BITS-1:0] cnt_acc_a,
   output logic [CNT_BITS-1:0] cnt_acc_b,
   output logic [CNT_BITS-1:0] cnt_timeout,
   output logic [CNT_BITS-1:0] cnt_drop
);

   typedef enum logic [1:0] {IDLE, TX0, TX1, WAIT} state_t;

   state_t      st, st_nx;
   logic [7:0]  win_cnt;
   logic [15:0] w1a_q, w1b_q;
   logic [15:0] w0_0, w0_1, w1_0, w1_1;
   logic [15:0] frame_a_d, frame_b_d;
   logic        tx_vld_d;
   logic        swap, start, drop, reply, expire;

   // Invalid LCTs contribute all-zero words so the MPC never sees stale fields
   assign w0_0 = lct0_vld ? {1'b1, lct0_q, lct0_pat, lct0_wg} : 16'h0000;
   assign w0_1 = lct1_vld ? {1'b1, lct1_q, lct1_pat, lct1_wg} : 16'h0000;
   assign w1_0 = lct0_vld ? {lct0_bend, lct0_key, bxn, csc_id, sync_err} : 16'h0000;
   assign w1_1 = lct1_vld ? {lct1_bend, lct1_key, bxn, csc_id, sync_err} : 16'h0000;

`ifdef LCT_SORT_EN
   assign swap = lct1_vld && (!lct0_vld || (lct1_q > lct0_q));
`else
   assign swap = 1'b0;
`endif

   assign start  = (st == IDLE) && lct_vld;
   assign drop   = (st != IDLE) && lct_vld;
   assign reply  = (st == WAIT) && mpc_accept_vld;
   assign expire = (st == WAIT) && !mpc_accept_vld && (win_cnt == 8'd0);

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v, input logic en);
      return (en && (v != {CNT_BITS{1'b1}})) ? v + {{(CNT_BITS-1){1'b0}}, 1'b1} : v;
   endfunction

   always_ff @(posedge clock or posedge global_reset) begin
      if (global_reset) begin
         st <= IDLE;
      end else begin
         st <= st_nx;
      end
   end

   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    if (start) st_nx = TX0;
         TX0:     st_nx = TX1;
         TX1:     st_nx = WAIT;
         WAIT:    if (reply || expire) st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   // Frame values are computed one clock ahead so the frame registers line up with the state
   always_comb begin
      frame_a_d = 16'h0000;
      frame_b_d = 16'h0000;
      tx_vld_d  = 1'b0;
      if (start) begin
         frame_a_d = swap ? w0_1 : w0_0;
         frame_b_d = swap ? w0_0 : w0_1;
         tx_vld_d  = 1'b1;
      end else if (st == TX0) begin
         frame_a_d = w1a_q;
         frame_b_d = w1b_q;
         tx_vld_d  = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge global_reset) begin
      if (global_reset) begin
         mpc_frame_a  <= 16'h0000;
         mpc_frame_b  <= 16'h0000;
         mpc_tx_vld   <= 1'b0;
         w1a_q        <= 16'h0000;
         w1b_q        <= 16'h0000;
         win_cnt      <= 8'd0;
         lct_accepted <= 2'b00;
         accept_done  <= 1'b0;
         mpc_timeout  <= 1'b0;
         cnt_sent     <= '0;
         cnt_acc_a    <= '0;
         cnt_acc_b    <= '0;
         cnt_timeout  <= '0;
         cnt_drop     <= '0;
      end else begin
         mpc_frame_a <= frame_a_d;
         mpc_frame_b <= frame_b_d;
         mpc_tx_vld  <= tx_vld_d;
         accept_done <= reply;
         mpc_timeout <= expire;
         if (start) begin
            w1a_q <= swap ? w1_1 : w1_0;
            w1b_q <= swap ? w1_0 : w1_1;
         end
         if (st == TX1) begin
            win_cnt <= 8'(ACC_WIN - 1);
         end else if ((st == WAIT) && (win_cnt != 8'd0)) begin
            win_cnt <= win_cnt - 8'd1;
         end
         if (reply) begin
            lct_accepted <= mpc_accept;
         end else if (expire) begin
            lct_accepted <= 2'b00;
         end
         cnt_sent    <= sat_inc(cnt_sent, start);
         cnt_drop    <= sat_inc(cnt_drop, drop);
         cnt_acc_a   <= sat_inc(cnt_acc_a, reply && mpc_accept[0]);
         cnt_acc_b   <= sat_inc(cnt_acc_b, reply && mpc_accept[1]);
         cnt_timeout <= sat_inc(cnt_timeout, expire);
      end
   end

endmodule

// File: tb/tb_lct_mpc_tx.sv
// tb/tb_lct_mpc_tx.sv - self-checking bench for lct_mpc_tx (vector table plus scoreboard)
module tb_lct_mpc_tx;

   typedef struct {
      logic       v0; logic [3:0] q0; logic [3:0] p0; logic [7:0] k0; logic b0; logic [6:0] g0;
      logic       v1; logic [3:0] q1; logic [3:0] p1; logic [7:0] k1; logic b1; logic [6:0] g1;
      logic [1:0] bx; logic [3:0] id; logic se;
      logic       swap;   // sort decision when LCT_SORT_EN is defined
      logic [1:0] acc;
      logic [3:0] rdly;   // WAIT clock index carrying the reply; 8 means no reply
      logic       drop;
   } vec_t;

   typedef struct {
      logic [15:0] w0a, w0b, w1a, w1b;
   } exp_t;

   logic        clock, global_reset;
   logic        lct_vld, lct0_vld, lct1_vld, lct0_bend, lct1_bend, sync_err;
   logic [3:0]  lct0_q, lct1_q, lct0_pat, lct1_pat, csc_id;
   logic [7:0]  lct0_key, lct1_key;
   logic [6:0]  lct0_wg, lct1_wg;
   logic [1:0]  bxn, mpc_accept, lct_accepted, s_lct_accepted;
   logic        mpc_accept_vld;
   logic [15:0] mpc_frame_a, mpc_frame_b, s_frame_a, s_frame_b;
   logic        mpc_tx_vld, accept_done, mpc_timeout, s_tx_vld, s_accept_done, s_timeout;
   logic [15:0] cnt_sent, cnt_acc_a, cnt_acc_b, cnt_timeout, cnt_drop;
   logic [3:0]  s_cnt_sent, s_cnt_acc_a, s_cnt_acc_b, s_cnt_timeout, s_cnt_drop;

   int   checks = 0;
   int   failures = 0;
   int   m_sent, m_acca, m_accb, m_to, m_drop;
   exp_t sbq[$];
   vec_t tbl[8];

   lct_mpc_tx #(.ACC_WIN(8), .CNT_BITS(16)) dut (
      .clock(clock), .global_reset(global_reset), .lct_vld(lct_vld),
      .lct0_vld(lct0_vld), .lct1_vld(lct1_vld), .lct0_q(lct0_q), .lct1_q(lct1_q),
      .lct0_pat(lct0_pat), .lct1_pat(lct1_pat), .lct0_key(lct0_key), .lct1_key(lct1_key),
      .lct0_bend(lct0_bend), .lct1_bend(lct1_bend), .lct0_wg(lct0_wg), .lct1_wg(lct1_wg),
      .bxn(bxn), .csc_id(csc_id), .sync_err(sync_err),
      .mpc_frame_a(mpc_frame_a), .mpc_frame_b(mpc_frame_b), .mpc_tx_vld(mpc_tx_vld),
      .mpc_accept_vld(mpc_accept_vld), .mpc_accept(mpc_accept), .lct_accepted(lct_accepted),
      .accept_done(accept_done), .mpc_timeout(mpc_timeout),
      .cnt_sent(cnt_sent), .cnt_acc_a(cnt_acc_a), .cnt_acc_b(cnt_acc_b),
      .cnt_timeout(cnt_timeout), .cnt_drop(cnt_drop)
   );

   lct_mpc_tx #(.ACC_WIN(8), .CNT_BITS(4)) dut_sat (
      .clock(clock), .global_reset(global_reset), .lct_vld(lct_vld),
      .lct0_vld(lct0_vld), .lct1_vld(lct1_vld), .lct0_q(lct0_q), .lct1_q(lct1_q),
      .lct0_pat(lct0_pat), .lct1_pat(lct1_pat), .lct0_key(lct0_key), .lct1_key(lct1_key),
      .lct0_bend(lct0_bend), .lct1_bend(lct1_bend), .lct0_wg(lct0_wg), .lct1_wg(lct1_wg),
      .bxn(bxn), .csc_id(csc_id), .sync_err(sync_err),
      .mpc_frame_a(s_frame_a), .mpc_frame_b(s_frame_b), .mpc_tx_vld(s_tx_vld),
      .mpc_accept_vld(mpc_accept_vld), .mpc_accept(mpc_accept), .lct_accepted(s_lct_accepted),
      .accept_done(s_accept_done), .mpc_timeout(s_timeout),
      .cnt_sent(s_cnt_sent), .cnt_acc_a(s_cnt_acc_a), .cnt_acc_b(s_cnt_acc_b),
      .cnt_timeout(s_cnt_timeout), .cnt_drop(s_cnt_drop)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic logic [63:0] exp_words(input vec_t v);
      logic [15:0] a0, a1, b0, b1;
      logic        sw;
      a0 = v.v0 ? {1'b1, v.q0, v.p0, v.g0} : 16'h0000;
      a1 = v.v0 ? {v.b0, v.k0, v.bx, v.id, v.se} : 16'h0000;
      b0 = v.v1 ? {1'b1, v.q1, v.p1, v.g1} : 16'h0000;
      b1 = v.v1 ? {v.b1, v.k1, v.bx, v.id, v.se} : 16'h0000;
`ifdef LCT_SORT_EN
      sw = v.swap;
`else
      sw = 1'b0;
`endif
      return sw ? {b0, a0, b1, a1} : {a0, b0, a1, b1};
   endfunction

   task automatic set_inputs(input vec_t v);
      lct0_vld = v.v0; lct0_q = v.q0; lct0_pat = v.p0; lct0_key = v.k0; lct0_bend = v.b0; lct0_wg = v.g0;
      lct1_vld = v.v1; lct1_q = v.q1; lct1_pat = v.p1; lct1_key = v.k1; lct1_bend = v.b1; lct1_wg = v.g1;
      bxn = v.bx; csc_id = v.id; sync_err = v.se;
   endtask

   task automatic chk_counters();
      chk("cnt_sent", 32'(cnt_sent), m_sent);
      chk("cnt_acc_a", 32'(cnt_acc_a), m_acca);
      chk("cnt_acc_b", 32'(cnt_acc_b), m_accb);
      chk("cnt_timeout", 32'(cnt_timeout), m_to);
      chk("cnt_drop", 32'(cnt_drop), m_drop);
   endtask

   task automatic run_pair(input vec_t v);
      exp_t        e, g;
      logic [63:0] w;
      w = exp_words(v);
      e.w0a = w[63:48]; e.w0b = w[47:32]; e.w1a = w[31:16]; e.w1b = w[15:0];
      sbq.push_back(e);
      set_inputs(v);
      lct_vld = 1'b1;
      m_sent++;
      step();                                   // N+1: word0
      lct_vld = 1'b0;
      chk("sb_depth", 32'(sbq.size()), 1);
      g = (sbq.size() != 0) ? sbq.pop_front() : '{16'h0, 16'h0, 16'h0, 16'h0};
      chk("tx_vld_w0", 32'(mpc_tx_vld), 1);
      chk("frame_a_w0", 32'(mpc_frame_a), 32'(g.w0a));
      chk("frame_b_w0", 32'(mpc_frame_b), 32'(g.w0b));
      chk("pulses_clear", 32'({accept_done, mpc_timeout}), 0);
      mpc_accept_vld = 1'b1;                    // stray reply outside WAIT
      mpc_accept = 2'b11;
      if (v.drop) begin
         lct_vld = 1'b1;
         lct0_q = ~lct0_q;
         lct1_wg = ~lct1_wg;
         m_drop++;
      end
      step();                                   // N+2: word1
      mpc_accept_vld = 1'b0;
      lct_vld = 1'b0;
      chk("tx_vld_w1", 32'(mpc_tx_vld), 1);
      chk("frame_a_w1", 32'(mpc_frame_a), 32'(g.w1a));
      chk("frame_b_w1", 32'(mpc_frame_b), 32'(g.w1b));
      chk("stray_reply_done", 32'(accept_done), 0);
      step();                                   // N+3: first WAIT clock
      for (int k = 0; k < 8; k++) begin
         chk("wait_tx_vld", 32'(mpc_tx_vld), 0);
         chk("wait_frames", {mpc_frame_a, mpc_frame_b}, 0);
         chk("wait_pulses", 32'({accept_done, mpc_timeout}), 0);
         if (v.drop && k == 0) begin
            lct_vld = 1'b1;
            m_drop++;
         end
         if (k == int'(v.rdly)) begin
            mpc_accept_vld = 1'b1;
            mpc_accept = v.acc;
         end
         step();
         lct_vld = 1'b0;
         mpc_accept_vld = 1'b0;
         if (k == int'(v.rdly)) break;
      end
      if (v.rdly >= 4'd8) begin
         chk("timeout_pulse", 32'(mpc_timeout), 1);
         chk("timeout_done", 32'(accept_done), 0);
         chk("timeout_accepted", 32'(lct_accepted), 0);
         m_to++;
      end else begin
         chk("accept_done", 32'(accept_done), 1);
         chk("accept_no_timeout", 32'(mpc_timeout), 0);
         chk("lct_accepted", 32'(lct_accepted), 32'(v.acc));
         m_acca += int'(v.acc[0]);
         m_accb += int'(v.acc[1]);
      end
      chk_counters();
   endtask

   initial begin
      tbl[0] = '{1'b1, 4'd11, 4'd2, 8'h21, 1'b1, 7'd5,   1'b1, 4'd15, 4'd3, 8'h42, 1'b0, 7'd9,
                 2'd1, 4'd3, 1'b0, 1'b1, 2'b11, 4'd2, 1'b0};
      tbl[1] = '{1'b1, 4'd13, 4'd4, 8'h10, 1'b0, 7'd20,  1'b1, 4'd13, 4'd5, 8'h11, 1'b1, 7'd21,
                 2'd2, 4'd5, 1'b1, 1'b0, 2'b01, 4'd0, 1'b0};
      tbl[2] = '{1'b0, 4'd7, 4'd6, 8'h77, 1'b1, 7'd33,   1'b1, 4'd6, 4'd7, 8'h88, 1'b1, 7'd44,
                 2'd3, 4'd9, 1'b0, 1'b1, 2'b10, 4'd2, 1'b0};
      tbl[3] = '{1'b0, 4'd3, 4'd1, 8'h05, 1'b1, 7'd1,    1'b0, 4'd4, 4'd2, 8'h06, 1'b1, 7'd2,
                 2'd0, 4'd1, 1'b1, 1'b0, 2'b00, 4'd8, 1'b0};
      tbl[4] = '{1'b1, 4'd9, 4'd8, 8'hA5, 1'b1, 7'd100,  1'b1, 4'd4, 4'd9, 8'h5A, 1'b0, 7'd101,
                 2'd1, 4'd15, 1'b1, 1'b0, 2'b11, 4'd7, 1'b0};
      tbl[5] = '{1'b1, 4'd2, 4'd10, 8'hC3, 1'b0, 7'd64,  1'b0, 4'd12, 4'd11, 8'h3C, 1'b1, 7'd65,
                 2'd2, 4'd6, 1'b0, 1'b0, 2'b00, 4'd1, 1'b1};
      tbl[6] = '{1'b1, 4'd0, 4'd12, 8'h01, 1'b0, 7'd127, 1'b1, 4'd1, 4'd13, 8'hFE, 1'b1, 7'd0,
                 2'd3, 4'd12, 1'b1, 1'b1, 2'b00, 4'd8, 1'b0};
      tbl[7] = '{1'b1, 4'd15, 4'd14, 8'h80, 1'b1, 7'd90, 1'b1, 4'd14, 4'd15, 8'h7F, 1'b0, 7'd91,
                 2'd0, 4'd10, 1'b0, 1'b0, 2'b01, 4'd3, 1'b0};

      global_reset = 1'b1;
      lct_vld = 1'b0;
      mpc_accept_vld = 1'b0;
      mpc_accept = 2'b00;
      set_inputs(tbl[3]);
      m_sent = 0; m_acca = 0; m_accb = 0; m_to = 0; m_drop = 0;
      step();
      step();
      chk("rst_frames", {mpc_frame_a, mpc_frame_b}, 0);
      chk("rst_flags", 32'({mpc_tx_vld, accept_done, mpc_timeout, lct_accepted}), 0);
      chk_counters();
      global_reset = 1'b0;
      step();

      // Reset asserted asynchronously while word1 is on the frames
      set_inputs(tbl[0]);
      lct_vld = 1'b1;
      step();
      lct_vld = 1'b0;
      step();
      chk("tx1_before_rst", 32'(mpc_tx_vld), 1);
      #2 global_reset = 1'b1;
      #1;
      chk("midrst_frames", {mpc_frame_a, mpc_frame_b}, 0);
      chk("midrst_flags", 32'({mpc_tx_vld, accept_done, mpc_timeout, lct_accepted}), 0);
      chk("midrst_sent", 32'(cnt_sent), 0);
      step();
      step();
      global_reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         chk("post_rst_quiet", 32'({mpc_tx_vld, mpc_timeout, accept_done}), 0);
         step();
      end
      chk_counters();

      for (int i = 0; i < 8; i++) begin
         run_pair(tbl[i]);
      end

      while (m_sent < 20) begin
         run_pair(tbl[1]);
      end
      chk("sat_cnt_sent", 32'(s_cnt_sent), 15);
      chk("sat_cnt_acc_a", 32'(s_cnt_acc_a), (m_acca > 15) ? 15 : m_acca);
      chk("sat_cnt_drop", 32'(s_cnt_drop), (m_drop > 15) ? 15 : m_drop);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lct_mpc_tx.md
# lct_mpc_tx

Downstream stage of the LCT quality encoder. Each clock with a valid LCT pair, the block sorts the two LCTs by 4-bit quality into lanes A and B. It then sends each lane to the Muon Port Card (MPC) as two 16-bit words on consecutive clocks, and waits a bounded window for the MPC accept reply. Status counters record sends, accepts, timeouts and dropped pairs.

## Interface
Parameters:
- `ACC_WIN`, 8: length of the accept window in clocks, legal range 1–255.
- `CNT_BITS`, 16: width of each status counter.

Ports:
- `clock` in 1: system clock.
- `global_reset` in 1: asynchronous, active-high reset.
- `lct_vld` in 1: LCT pair present in this clock.
- `lct0_vld`, `lct1_vld` in 1: per-LCT valid.
- `lct0_q`, `lct1_q` in 4: quality code from the quality encoder.
- `lct0_pat`, `lct1_pat` in 4: CLCT pattern number.
- `lct0_key`, `lct1_key` in 8: key half-strip.
- `lct0_bend`, `lct1_bend` in 1: bend direction.
- `lct0_wg`, `lct1_wg` in 7: key wire group.
- `bxn` in 2: low bits of the bunch-crossing number.
- `csc_id` in 4: chamber ID.
- `sync_err` in 1: TTC sync error flag.
- `mpc_frame_a`, `mpc_frame_b` out 16: lane A and lane B words.
- `mpc_tx_vld` out 1: high while word0 or word1 is on the frame outputs.
- `mpc_accept_vld` in 1: MPC reply strobe.
- `mpc_accept` in 2: accept bits; bit0 is lane A, bit1 is lane B.
- `lct_accepted` out 2: accept bits latched from the last reply.
- `accept_done` out 1: 1-clock pulse when a reply is taken.
- `mpc_timeout` out 1: 1-clock pulse when the accept window expires with no reply.
- `cnt_sent`, `cnt_acc_a`, `cnt_acc_b`, `cnt_timeout`, `cnt_drop` out `CNT_BITS`: status counters.

## Operation
- FSM states: IDLE, TX0, TX1, WAIT.
- IDLE:
  - `lct_vld`=1 latches the sorted lanes plus `bxn`, `csc_id` and `sync_err`, then moves to TX0.
  - `lct_vld`=1 with both `lct0_vld` and `lct1_vld` at 0 still transmits two all-zero-payload frames.
- Sort: the higher-quality LCT goes to lane A.
  - Lanes are swapped only when `lct1_vld`=1 and either `lct0_vld`=0 or `lct1_q` > `lct0_q` (unsigned).
  - On a quality tie the original order is kept.
  - An invalid lane carries all-zero fields.
- Word0 per lane: {vld, q[3:0], pat[3:0], wg[6:0]}.
- Word1 per lane: {bend, key[7:0], bxn[1:0], csc_id[3:0], sync_err}.
- TX0 drives word0, TX1 drives word1, with `mpc_tx_vld`=1 in both. `cnt_sent` increments once, on entry to TX0.
- WAIT:
  - The window counter loads `ACC_WIN`-1 on entry and decrements each clock.
  - `mpc_accept_vld`=1 latches `mpc_accept` into `lct_accepted`, pulses `accept_done`, increments `cnt_acc_a` and/or `cnt_acc_b` for each set bit, and returns to IDLE.
  - If `mpc_accept_vld` is still 0 in the clock where the counter is 0, `mpc_timeout` pulses, `cnt_timeout` increments, `lct_accepted` is cleared to 0, and the FSM returns to IDLE.
  - A reply in the same clock as the counter reaching 0 counts as an accept, not a timeout.
- `mpc_accept_vld` seen outside WAIT is ignored.
- `lct_vld`=1 in TX0, TX1 or WAIT drops the pair: `cnt_drop` increments and no other state changes.
- Frame outputs are 0 whenever `mpc_tx_vld`=0.
- Counters saturate at all-ones and never wrap.

## Timing
- `lct_vld` sampled at edge N gives word0 at N+1 and word1 at N+2. WAIT covers N+3 through N+2+`ACC_WIN`.
- A new pair can be accepted in the clock after the FSM returns to IDLE. The minimum spacing between pairs is 4 clocks (IDLE→TX0→TX1→WAIT with an immediate reply→IDLE).
- All outputs are registered.
- Reset values: FSM in IDLE; frames, `mpc_tx_vld`, `lct_accepted`, `accept_done`, `mpc_timeout` and all counters at 0.
- Asserting reset mid-transfer aborts at once. No timeout pulse is generated, and the in-flight pair is not counted as dropped.

## Configuration
- `LCT_SORT_EN` defined: quality sort as described in Operation.
- `LCT_SORT_EN` undefined: no sort.
  - `lct0` always drives lane A and `lct1` always drives lane B, even when `lct0` is invalid.
  - All other behaviour is identical.

## Test plan
- Sort:
  - Stimulus: `lct0_q`=11 and `lct1_q`=15, both valid, `lct0_wg`=5, `lct1_wg`=9.
  - Required: at N+1 lane A word0 is {1,15,p1,9}. With `LCT_SORT_EN` undefined, lane A word0 is {1,11,p0,5}.
- Tie and single-valid:
  - Stimulus 1: equal q=13 on both LCTs. Required: order kept.
  - Stimulus 2: only `lct1_vld`=1. Required: lane A carries `lct1`, `mpc_frame_b`=0x0000 in both words.
- Accept:
  - Stimulus: `mpc_accept_vld` pulsed with `mpc_accept`=2'b10 at N+5.
  - Required: `accept_done` pulses, `lct_accepted`=2'b10, `cnt_acc_b`=1, FSM back in IDLE.
- Timeout:
  - Stimulus: `ACC_WIN`=8, no reply.
  - Required: `mpc_timeout` pulses exactly once, in the last WAIT clock (N+10); `cnt_timeout`=1; `lct_accepted`=0. A reply arriving at N+10 instead gives an accept and no timeout.
- Drop and saturation:
  - Stimulus 1: `lct_vld` asserted at N+1 and N+3. Required: `cnt_drop`=2 and frames unchanged.
  - Stimulus 2: `CNT_BITS`=4, 20 sends. Required: `cnt_sent`=15.
- Reset mid-operation:
  - Stimulus: `global_reset` asserted asynchronously during TX1.
  - Required: all outputs 0 immediately, no timeout pulse, and the next `lct_vld` is transmitted normally.
